i2c_mpu_responder: RTL and testbench
====================================

// Module: i2c_mpu_responder
// PURPOSE
//  I2C target (responder) emulating the MPU-6050 register map seen by the gyro I2C initiator.
//  Sits on the simulation/loopback side of the I2C bus in place of the real sensor.
//  Serves gyro words supplied on ports, a WHO_AM_I constant and a writable PWR_MGMT_1 register.
//  Lets the gyro read path be exercised without hardware.
// PARAMETERS
//  DEV_ADDR    7'h68  7-bit target address matched after START
//  WHO_AM_I    8'h68  value returned at register 0x75
//  PWR_RESET   8'h40  reset value of PWR_MGMT_1 (reg 0x6B)
// PORTS
//  clk_in        in   1   system clock, >= 8x SCL rate
//  rst_in        in   1   synchronous, active-high reset
//  scl_in        in   1   I2C clock from bus (async)
//  sda_in        in   1   I2C data from bus (async)
//  sda_oe_out    out  1   1 = pull SDA low (open-drain); 0 = release
//  gx_in         in   16  gyro X word, served at regs 0x43/0x44 (H/L)
//  gy_in         in   16  gyro Y word, regs 0x45/0x46
//  gz_in         in   16  gyro Z word, regs 0x47/0x48
//  pwr_mgmt_out  out  8   current PWR_MGMT_1 contents
//  busy_out      out  1   1 from START until STOP
// BEHAVIOUR
//  Reset: sda_oe_out=0, busy_out=0, pwr_mgmt_out=PWR_RESET, state=IDLE, reg_ptr=0.
//  Inputs: 2-flop synchronisers on scl_in/sda_in; edges from synced values (2-3 clk latency).
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both honoured in ANY state.
//  START (incl. repeated) -> ADDR, bit_cnt=0, sda_oe_out released same cycle.
//  STOP -> IDLE, sda_oe_out=0, busy_out=0 next cycle.
//  Sample SDA on SCL rising edge; change sda_oe_out only on SCL falling edge (+1 clk).
//  States:
//   IDLE     : wait for START.
//   ADDR     : shift 8 bits MSB first (7 addr + R/W). On 8th SCL fall: match -> ADDR_ACK;
//              mismatch -> IGNORE (no drive until STOP/START).
//   ADDR_ACK : drive low for 9th bit; on its SCL fall: R/W=0 -> PTR, R/W=1 -> snapshot
//              gx/gy/gz into shadow regs, load byte at reg_ptr, -> RD_DATA.
//   PTR      : shift 8 bits into reg_ptr -> PTR_ACK (ack) -> WR_DATA.
//   WR_DATA  : shift byte; if reg_ptr==0x6B update pwr_mgmt_out; other regs ignore data.
//              Ack every byte, reg_ptr++ after ack.
//   RD_DATA  : sda_oe_out = ~bit for 8 bits; release on 8th fall -> RD_ACK.
//   RD_ACK   : sample master bit on 9th rise: 0 (ACK) -> reg_ptr++, load next byte,
//              RD_DATA; 1 (NACK) -> IGNORE.
//  Map: 0x43..0x48 shadow gyro bytes (H first); 0x75 WHO_AM_I; 0x6B PWR_MGMT_1;
//       all other addresses read 8'h00.
//  reg_ptr is 8 bits, wraps 0xFF -> 0x00.
//  Shadow snapshot taken once per read transaction: multi-byte read is coherent even if
//  g*_in changes mid-burst.
//  Write to PWR_MGMT_1 takes effect the cycle after the 8th SCL rise of the data byte.
//  rst_in mid-transfer: immediate IDLE, bus released; no partial write commits.
// STRUCTURE
//  Package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK,
//   RD_DATA, RD_ACK, IGNORE) and MPU register address localparams (GYRO_XOUT_H=0x43,
//   PWR_MGMT_1=0x6B, WHO_AM_I_REG=0x75).
//  Sub-module i2c_line_sync: synchronisers plus scl_rise/scl_fall/start/stop pulses.
//  Top: FSM, bit counter, shift register, reg_ptr, shadow regs.
// TESTING
//  1. Write 0x68/W, ptr 0x75, Sr, 0x68/R, 1 byte, NACK, P -> three ACKs low, data 0x68, busy 0 after P.
//  2. gx=0x1234, gy=0xABCD, gz=0x8001; burst read 6 bytes from 0x43 -> 12 34 AB CD 80 01;
//     change gx mid-burst -> bytes unchanged.
//  3. Write 0x68/W, 0x6B, 0x00, P -> pwr_mgmt_out 0x40 -> 0x00; reg 0x6C write -> no change.
//  4. Address 0x69 -> SDA never driven during ACK slot; next valid transaction to 0x68 acks normally.
//  5. Read from ptr 0xFF, 2 bytes -> 0x00 then reg 0x00 value 0x00; reg_ptr wrapped.
//  6. rst_in pulse mid RD_DATA with sda_oe_out=1 -> sda_oe_out=0 next cycle, state IDLE;
//     STOP mid-byte also releases bus.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the MPU-6050 I2C responder.
//   i2c_state_e : protocol FSM states
//   register addresses of the emulated MPU-6050 map
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
  localparam logic [7:0] GYRO_XOUT_L  = 8'h44;
  localparam logic [7:0] GYRO_YOUT_H  = 8'h45;
  localparam logic [7:0] GYRO_YOUT_L  = 8'h46;
  localparam logic [7:0] GYRO_ZOUT_H  = 8'h47;
  localparam logic [7:0] GYRO_ZOUT_L  = 8'h48;
  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] WHO_AM_I_REG = 8'h75;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the asynchronous SCL/SDA bus lines into the clk_in domain and
// derives single-cycle bus event pulses from the synchronised values.
//   clk_in, rst_in : system clock, synchronous active-high reset
//   scl_in, sda_in : raw bus lines
//   sda            : synchronised SDA level
//   scl_rise/scl_fall : one-cycle SCL edge pulses
//   start/stop     : one-cycle START / STOP condition pulses
module i2c_line_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;
  logic       scl;

  // Reset to the idle-bus level so no spurious edge is seen when leaving reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  // SDA may only change while SCL is high for a START/STOP, so both SCL samples must be high.
  assign start    = scl & scl_q & sda_q & ~sda;
  assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_mpu_responder.sv
// I2C target emulating the MPU-6050 register map used by the gyro initiator.
//   clk_in, rst_in : system clock (>= 8x SCL), synchronous active-high reset
//   scl_in, sda_in : asynchronous bus lines
//   sda_oe_out     : 1 pulls SDA low (open drain)
//   gx_in/gy_in/gz_in : gyro words served at 0x43..0x48 (high byte first)
//   pwr_mgmt_out   : PWR_MGMT_1 register contents
//   busy_out       : high between START and STOP
module i2c_mpu_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h68,
  parameter logic [7:0] WHO_AM_I  = 8'h68,
  parameter logic [7:0] PWR_RESET = 8'h40
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe_out,
  input  logic [15:0] gx_in,
  input  logic [15:0] gy_in,
  input  logic [15:0] gz_in,
  output logic [7:0]  pwr_mgmt_out,
  output logic        busy_out
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_line_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e  state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic        rw, rw_n;
  logic [7:0]  reg_ptr, reg_ptr_n;
  logic [7:0]  pwr, pwr_n;
  logic        sda_oe, sda_oe_n;
  logic        busy, busy_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  tx, tx_n;
  logic [15:0] gx_sh, gy_sh, gz_sh;
  logic        snap;
  logic [7:0]  rd_byte;

  function automatic logic [7:0] reg_read(input logic [7:0]  addr,
                                          input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic [15:0] z,
                                          input logic [7:0]  pm);
    case (addr)
      GYRO_XOUT_H:  reg_read = x[15:8];
      GYRO_XOUT_L:  reg_read = x[7:0];
      GYRO_YOUT_H:  reg_read = y[15:8];
      GYRO_YOUT_L:  reg_read = y[7:0];
      GYRO_ZOUT_H:  reg_read = z[15:8];
      GYRO_ZOUT_L:  reg_read = z[7:0];
      PWR_MGMT_1:   reg_read = pm;
      WHO_AM_I_REG: reg_read = WHO_AM_I;
      default:      reg_read = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      rw      <= 1'b0;
      reg_ptr <= 8'h00;
      pwr     <= PWR_RESET;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      rw      <= rw_n;
      reg_ptr <= reg_ptr_n;
      pwr     <= pwr_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
    end
  end

  always_ff @(posedge clk_in) begin
    shift <= shift_n;
    tx    <= tx_n;
    if (snap) begin
      gx_sh <= gx_in;
      gy_sh <= gy_in;
      gz_sh <= gz_in;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rw_n      = rw;
    reg_ptr_n = reg_ptr;
    pwr_n     = pwr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    shift_n   = shift;
    tx_n      = tx;
    snap      = 1'b0;
    rd_byte   = 8'h00;

    if (start) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b1;
    end else if (stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            if (shift[7:1] == DEV_ADDR) begin
              state_n  = ADDR_ACK;
              rw_n     = shift[0];
              sda_oe_n = 1'b1;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (rw) begin
              // Live inputs equal the values being captured into the shadow this cycle.
              snap     = 1'b1;
              rd_byte  = reg_read(reg_ptr, gx_in, gy_in, gz_in, pwr);
              tx_n     = rd_byte;
              sda_oe_n = ~rd_byte[7];
              state_n  = RD_DATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = PTR;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            reg_ptr_n = shift;
            sda_oe_n  = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = PTR_ACK;
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = WR_DATA;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
            // Commit on the last data bit so an aborted byte never reaches the register.
            if (bit_cnt == 4'd7 && reg_ptr == PWR_MGMT_1)
              pwr_n = {shift[6:0], sda};
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n  = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            reg_ptr_n = reg_ptr + 8'd1;
            state_n   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 4'd0;
              state_n   = RD_ACK;
            end else begin
              // bit_cnt counts bits already clocked out; ~bit_cnt selects bit 7-bit_cnt.
              sda_oe_n = ~tx[~bit_cnt[2:0]];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda) begin
              reg_ptr_n = reg_ptr + 8'd1;
              tx_n      = reg_read(reg_ptr + 8'd1, gx_sh, gy_sh, gz_sh, pwr);
              bit_cnt_n = 4'd0;
              state_n   = RD_DATA;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe_out   = sda_oe;
  assign pwr_mgmt_out = pwr;
  assign busy_out     = busy;

endmodule

// File: tb/tb_i2c_mpu_responder.sv
// Bench for i2c_mpu_responder: bit-banged I2C initiator, transaction-level
// model of the MPU register map, per-cycle output comparison and literal checks.
module tb_i2c_mpu_responder;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] gx = 16'h0, gy = 16'h0, gz = 16'h0;
  logic        sda_oe;
  logic [7:0]  pwr;
  logic        busy;
  wire         sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_mpu_responder dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe_out   (sda_oe),
    .gx_in        (gx),
    .gy_in        (gy),
    .gz_in        (gz),
    .pwr_mgmt_out (pwr),
    .busy_out     (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_PTR, M_WR, M_RD, M_IGN} mode_e;
  mode_e       mode = M_IDLE;
  logic [7:0]  m_pwr = 8'h40;
  logic [7:0]  m_ptr = 8'h00;
  logic        m_busy = 1'b0;
  logic        m_oe = 1'b0;
  logic [15:0] m_snap [3];

  function automatic logic [7:0] m_reg(input logic [7:0] a);
    int idx;
    idx = int'(a) - 'h43;
    if (idx >= 0 && idx < 6)
      return (idx % 2 == 0) ? m_snap[idx / 2][15:8] : m_snap[idx / 2][7:0];
    if (a == 8'h6B) return m_pwr;
    if (a == 8'h75) return 8'h68;
    return 8'h00;
  endfunction

  // Outputs must match the model once the bus inputs have been quiet long
  // enough to pass the synchronisers.
  initial begin
    logic [2:0] prev;
    int quiet;
    prev = {rst, scl_m, sda_m};
    quiet = 0;
    forever begin
      @(negedge clk);
      if ({rst, scl_m, sda_m} == prev) quiet++;
      else quiet = 0;
      prev = {rst, scl_m, sda_m};
      if (quiet >= 4) begin
        chk("cyc_pwr", pwr, m_pwr);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_oe", sda_oe, m_oe);
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; m_busy = 1'b1; m_oe = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; m_busy = 1'b0; m_oe = 1'b0; mode = M_IDLE; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit commit,
                           input bit oe_next, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q();
      scl_m = 1'b1;
      if (i == 0 && commit) m_pwr = b;
      wait_q(); wait_q();
      scl_m = 1'b0;
      if (i == 0) m_oe = exp_ack;
      wait_q();
    end
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    s = sda_line; wait_q();
    scl_m = 1'b0; m_oe = oe_next; wait_q();
    ack = ~s;
    chk("ack_slot", ack, exp_ack);
  endtask

  task automatic addr_phase(input logic [6:0] a, input bit rd, output bit ack);
    bit match;
    logic [7:0] first;
    match = (a == 7'h68);
    first = 8'h00;
    i2c_start();
    if (match && rd) begin
      m_snap = '{gx, gy, gz};
      first = m_reg(m_ptr);
    end
    send_byte({a, rd}, match, 1'b0, match & rd & ~first[7], ack);
    mode = !match ? M_IGN : (rd ? M_RD : M_PTR);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    bit ack;
    send_byte(b, (mode == M_PTR) || (mode == M_WR),
              (mode == M_WR) && (m_ptr == 8'h6B), 1'b0, ack);
    if (mode == M_PTR) begin
      m_ptr = b;
      mode = M_WR;
    end else if (mode == M_WR) begin
      m_ptr = m_ptr + 8'd1;
    end
  endtask

  task automatic rd_byte(input bit master_ack, output logic [7:0] b);
    logic [7:0] exp, nxt;
    exp = m_reg(m_ptr);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b[i] = sda_line; wait_q();
      scl_m = 1'b0;
      m_oe = (i > 0) ? ~exp[i - 1] : 1'b0;
      wait_q();
    end
    sda_m = ~master_ack; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0;
    if (master_ack) begin
      m_ptr = m_ptr + 8'd1;
      nxt = m_reg(m_ptr);
      m_oe = ~nxt[7];
    end else begin
      mode = M_IGN;
      m_oe = 1'b0;
    end
    wait_q();
    chk("rd_data", b, exp);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    bit ack;
    addr_phase(7'h68, 1'b0, ack);
    wr_byte(p);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: timeout, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bit ack;
    logic [7:0] got;
    logic [7:0] exp2 [6];
    int n;
    int kind;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_pwr", pwr, 8'h40);
    chk("rst_busy", busy, 1'b0);
    chk("rst_oe", sda_oe, 1'b0);

    // WHO_AM_I read with repeated start
    addr_phase(7'h68, 1'b0, ack); chk("t1_ack_addr", ack, 1'b1);
    wr_byte(8'h75);
    addr_phase(7'h68, 1'b1, ack); chk("t1_ack_rd", ack, 1'b1);
    rd_byte(1'b0, got); chk("t1_whoami", got, 8'h68);
    i2c_stop();
    @(negedge clk); chk("t1_busy_after_p", busy, 1'b0);

    // coherent gyro burst
    gx = 16'h1234; gy = 16'hABCD; gz = 16'h8001;
    exp2 = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h80, 8'h01};
    set_ptr(8'h43);
    addr_phase(7'h68, 1'b1, ack);
    for (int k = 0; k < 6; k++) begin
      rd_byte(k < 5, got);
      chk("t2_burst", got, exp2[k]);
      if (k == 1) gx = 16'h5A5A;
    end
    i2c_stop();

    // PWR_MGMT_1 write, then write to a neighbour
    set_ptr(8'h6B); wr_byte(8'h00); i2c_stop();
    @(negedge clk); chk("t3_pwr_written", pwr, 8'h00);
    set_ptr(8'h6C); wr_byte(8'h55); i2c_stop();
    @(negedge clk); chk("t3_pwr_kept", pwr, 8'h00);

    // foreign address ignored, then normal transaction
    addr_phase(7'h69, 1'b0, ack); chk("t4_nack", ack, 1'b0);
    wr_byte(8'h6B); wr_byte(8'h77); i2c_stop();
    @(negedge clk); chk("t4_pwr", pwr, 8'h00);
    addr_phase(7'h68, 1'b0, ack); chk("t4_ack_after", ack, 1'b1);
    wr_byte(8'h10); i2c_stop();

    // pointer wrap
    set_ptr(8'hFF);
    addr_phase(7'h68, 1'b1, ack);
    rd_byte(1'b1, got); chk("t5_ff", got, 8'h00);
    rd_byte(1'b0, got); chk("t5_00", got, 8'h00);
    i2c_stop();
    set_ptr(8'h6A); wr_byte(8'h11); wr_byte(8'h22); i2c_stop();
    @(negedge clk); chk("t5_autoinc_wr", pwr, 8'h22);

    // randomized transactions
    for (int t = 0; t < 20; t++) begin
      gx = 16'($urandom); gy = 16'($urandom); gz = 16'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        addr_phase(7'h68 ^ 7'($urandom_range(1, 127)), 1'($urandom_range(0, 1)), ack);
        if ($urandom_range(0, 1) == 1 && mode == M_IGN) wr_byte(8'($urandom));
        i2c_stop();
      end else if (kind < 4) begin
        case ($urandom_range(0, 3))
          0: set_ptr(8'h6B);
          1: set_ptr(8'h6A);
          2: set_ptr(8'h75);
          default: set_ptr(8'($urandom));
        endcase
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) wr_byte(8'($urandom));
        i2c_stop();
      end else begin
        if (kind != 9) begin
          case ($urandom_range(0, 3))
            0: set_ptr(8'($urandom_range('h43, 'h48)));
            1: set_ptr(8'h6B);
            2: set_ptr(8'hFE);
            default: set_ptr(8'($urandom));
          endcase
        end
        addr_phase(7'h68, 1'b1, ack);
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          rd_byte(k < n - 1, got);
          if (k == 0) gx = 16'($urandom);
        end
        i2c_stop();
      end
    end

    // reset while driving SDA low
    set_ptr(8'h75);
    addr_phase(7'h68, 1'b1, ack);
    @(negedge clk); chk("t6_oe_before_rst", sda_oe, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    m_pwr = 8'h40; m_ptr = 8'h00; m_busy = 1'b0; m_oe = 1'b0; mode = M_IDLE;
    @(posedge clk);
    @(negedge clk);
    chk("t6_oe_rst", sda_oe, 1'b0);
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_pwr_rst", pwr, 8'h40);
    #1 rst = 1'b0;
    wait_q();
    i2c_stop();

    // STOP in the middle of a read byte
    set_ptr(8'h75);
    addr_phase(7'h68, 1'b1, ack);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; m_oe = 1'b0; wait_q();
    i2c_stop();
    @(negedge clk);
    chk("t6_busy_stop", busy, 1'b0);
    chk("t6_oe_stop", sda_oe, 1'b0);
    for (int k = 0; k < 3; k++) begin
      scl_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
    end
    @(negedge clk);
    chk("t6_idle_after_stop", sda_oe, 1'b0);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
